// File: rtl/totd_window_trigger.sv
// ToTd window trigger: per-PMT over-threshold occupancy over a sliding WINDOW-tick window, with a multiplicity trigger.
// Optional single-pulse/holdoff output mode is enabled by defining COMPATIBILITY_TOTD_HOLDOFF_EN.
module totd_window_trigger #(
    parameter int WINDOW    = 120,
    parameter int OCC_WIDTH = 7
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [1:0]           ENABLE40,
    input  logic [11:0]          ADC_IN0,
    input  logic [11:0]          ADC_IN1,
    input  logic [11:0]          ADC_IN2,
    input  logic [11:0]          THRES0,
    input  logic [11:0]          THRES1,
    input  logic [11:0]          THRES2,
    input  logic [OCC_WIDTH-1:0] OCC_REQ,
    input  logic [1:0]           MULT_REQ,
    input  logic [2:0]           PMT_MASK,
    output logic [OCC_WIDTH-1:0] OCC0,
    output logic [OCC_WIDTH-1:0] OCC1,
    output logic [OCC_WIDTH-1:0] OCC2,
    output logic                 TRIG
);

    logic                 tick;
    logic [11:0]          adc   [3];
    logic [11:0]          thres [3];
    logic [OCC_WIDTH-1:0] occ_w [3];
    logic                 qual  [3];
    logic [1:0]           nq;
    logic                 cond;
    logic                 trig_reg;

    assign tick     = (ENABLE40 == 2'd0);
    assign adc[0]   = ADC_IN0;
    assign adc[1]   = ADC_IN1;
    assign adc[2]   = ADC_IN2;
    assign thres[0] = THRES0;
    assign thres[1] = THRES1;
    assign thres[2] = THRES2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : pmt_g
            logic                 over_reg;
            logic [WINDOW-1:0]    line_reg;
            logic [WINDOW:0]      line_ext;
            logic [OCC_WIDTH-1:0] occ_reg;
            logic [OCC_WIDTH-1:0] occ_next;

            // Extended vector keeps the shift valid even for WINDOW == 1.
            assign line_ext = {line_reg, over_reg};
            assign occ_next = occ_reg
                            + {{(OCC_WIDTH-1){1'b0}}, over_reg}
                            - {{(OCC_WIDTH-1){1'b0}}, line_reg[WINDOW-1]};

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    over_reg <= 1'b0;
                    line_reg <= '0;
                    occ_reg  <= '0;
                end else if (tick) begin
                    over_reg <= (adc[gi] > thres[gi]);
                    line_reg <= line_ext[WINDOW-1:0];
                    occ_reg  <= occ_next;
                end
            end

            assign occ_w[gi] = occ_reg;
            assign qual[gi]  = !PMT_MASK[gi] && (occ_reg >= OCC_REQ);
        end
    endgenerate

    assign nq   = {1'b0, qual[0]} + {1'b0, qual[1]} + {1'b0, qual[2]};
    assign cond = (MULT_REQ != 2'd0) && (nq >= MULT_REQ);

`ifdef COMPATIBILITY_TOTD_HOLDOFF_EN
    logic [OCC_WIDTH-1:0] hold_reg;
    logic                 cond_prev_reg;

    // Edge history is cleared while holding off, so a condition still high
    // when the holdoff expires counts as a fresh rising edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            trig_reg      <= 1'b0;
            hold_reg      <= '0;
            cond_prev_reg <= 1'b0;
        end else if (tick) begin
            if (hold_reg != '0) begin
                hold_reg      <= hold_reg - 1'b1;
                trig_reg      <= 1'b0;
                cond_prev_reg <= 1'b0;
            end else begin
                cond_prev_reg <= cond;
                if (cond && !cond_prev_reg) begin
                    trig_reg <= 1'b1;
                    hold_reg <= OCC_WIDTH'(WINDOW);
                end else begin
                    trig_reg <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            trig_reg <= 1'b0;
        end else if (tick) begin
            trig_reg <= cond;
        end
    end
`endif

    assign OCC0 = occ_w[0];
    assign OCC1 = occ_w[1];
    assign OCC2 = occ_w[2];
    assign TRIG = trig_reg;

endmodule

// File: tb/tb_totd_window_trigger.sv
// Randomized + directed bench for totd_window_trigger against a sliding-window history model.
module tb_totd_window_trigger;

    localparam int WINDOW = 120;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [1:0]  ENABLE40;
    logic [11:0] ADC_IN0, ADC_IN1, ADC_IN2;
    logic [11:0] THRES0, THRES1, THRES2;
    logic [6:0]  OCC_REQ;
    logic [1:0]  MULT_REQ;
    logic [2:0]  PMT_MASK;
    logic [6:0]  OCC0, OCC1, OCC2;
    logic        TRIG;

    totd_window_trigger #(.WINDOW(WINDOW), .OCC_WIDTH(7)) dut (
        .CLK(CLK), .RSTN(RSTN), .ENABLE40(ENABLE40),
        .ADC_IN0(ADC_IN0), .ADC_IN1(ADC_IN1), .ADC_IN2(ADC_IN2),
        .THRES0(THRES0), .THRES1(THRES1), .THRES2(THRES2),
        .OCC_REQ(OCC_REQ), .MULT_REQ(MULT_REQ), .PMT_MASK(PMT_MASK),
        .OCC0(OCC0), .OCC1(OCC1), .OCC2(OCC2), .TRIG(TRIG)
    );

    always #4 CLK = ~CLK;

    int tests_run = 0;
    int failures  = 0;
    int phase_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: occupancy is the number of over-threshold samples among
    // the WINDOW tick samples captured before the current one.
    logic [2:0] hist[$];
    int  exp_occ [3];
    int  exp_trig;
    int  tick_idx;
    int  last_pulse;
    bit  cond_last;
    bit  prev_in_hold;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) exp_occ[i] = 0;
        exp_trig     = 0;
        tick_idx     = 0;
        last_pulse   = -100000;
        cond_last    = 1'b0;
        prev_in_hold = 1'b0;
    endfunction

    function automatic void model_tick();
        int  nq;
        bit  cond;
        logic [2:0] s;
        nq = 0;
        for (int i = 0; i < 3; i++)
            if (!PMT_MASK[i] && exp_occ[i] >= int'(OCC_REQ)) nq++;
        cond = (MULT_REQ != 0) && (nq >= int'(MULT_REQ));
`ifdef COMPATIBILITY_TOTD_HOLDOFF_EN
        begin
            bit in_hold;
            bit pulse;
            in_hold = (tick_idx - last_pulse) <= WINDOW;
            pulse   = cond && !in_hold && (!cond_last || prev_in_hold);
            exp_trig = pulse ? 1 : 0;
            if (pulse) last_pulse = tick_idx;
            cond_last    = cond;
            prev_in_hold = in_hold;
        end
`else
        exp_trig = cond ? 1 : 0;
`endif
        s[0] = ADC_IN0 > THRES0;
        s[1] = ADC_IN1 > THRES1;
        s[2] = ADC_IN2 > THRES2;
        hist.push_back(s);
        if (hist.size() > WINDOW + 1) void'(hist.pop_front());
        for (int i = 0; i < 3; i++) begin
            exp_occ[i] = 0;
            for (int j = 0; j < hist.size() - 1; j++) exp_occ[i] += hist[j][i];
        end
        tick_idx++;
    endfunction

    task automatic cycle();
        @(posedge CLK);
        #1;
        if (RSTN && ENABLE40 == 2'd0) model_tick();
        check("occ0", OCC0, exp_occ[0]);
        check("occ1", OCC1, exp_occ[1]);
        check("occ2", OCC2, exp_occ[2]);
        check("trig", TRIG, exp_trig);
        ENABLE40 = (ENABLE40 == 2'd2) ? 2'd0 : ENABLE40 + 2'd1;
    endtask

    // One tick edge with the given samples; non-tick cycles optionally carry junk.
    task automatic run_tick(input logic [11:0] a0, input logic [11:0] a1,
                            input logic [11:0] a2, input bit garble);
        bit done;
        done = 1'b0;
        while (!done) begin
            if (ENABLE40 == 2'd0 || !garble) begin
                ADC_IN0 = a0; ADC_IN1 = a1; ADC_IN2 = a2;
            end else begin
                ADC_IN0 = 12'($urandom); ADC_IN1 = 12'($urandom); ADC_IN2 = 12'($urandom);
            end
            done = (ENABLE40 == 2'd0);
            cycle();
        end
    endtask

    task automatic midstream_reset();
        #1;
        RSTN = 1'b0;
        #1;
        check("rst_occ0", OCC0, 0);
        check("rst_occ1", OCC1, 0);
        check("rst_occ2", OCC2, 0);
        check("rst_trig", TRIG, 0);
        model_reset();
        repeat (3) cycle();
        #3 RSTN = 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) run_tick(12'd0, 12'd0, 12'd0, 1'b0);
    endtask

    task automatic phase_done(input string name);
        phase_cnt++;
        $display("[TB] phase %0d %s complete, %0d checks so far", phase_cnt, name, tests_run);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        int trig_ticks;
        int rises;
        bit trig_any;
        logic prev_trig;

        RSTN = 1'b0; ENABLE40 = 2'd0;
        ADC_IN0 = 0; ADC_IN1 = 0; ADC_IN2 = 0;
        THRES0 = 100; THRES1 = 100; THRES2 = 100;
        OCC_REQ = 7'd13; MULT_REQ = 2'd0; PMT_MASK = 3'b000;
        model_reset();
        repeat (3) cycle();
        #3 RSTN = 1'b1;
        drain(10);
        phase_done("reset");

        // Window fill on PMT0 only.
        THRES1 = 12'd4095; THRES2 = 12'd4095;
        OCC_REQ = 7'd13; MULT_REQ = 2'd1; PMT_MASK = 3'b110;
        peak = 0; trig_ticks = 0;
        repeat (13) begin
            run_tick(12'd200, 12'd0, 12'd0, 1'b0);
            if (TRIG) trig_ticks++;
        end
        repeat (140) begin
            run_tick(12'd0, 12'd0, 12'd0, 1'b0);
            if (int'(OCC0) > peak) peak = int'(OCC0);
            if (TRIG) trig_ticks++;
        end
        check("fill_peak", peak, 13);
        check("fill_trig_ticks", trig_ticks, 108);
        phase_done("window fill");

        // Multiplicity.
        THRES1 = 12'd100; THRES2 = 12'd100;
        OCC_REQ = 7'd20; MULT_REQ = 2'd2; PMT_MASK = 3'b000;
        repeat (20) run_tick(12'd200, 12'd200, 12'd0, 1'b0);
        drain(5);
        check("mult2", TRIG, 1);
        MULT_REQ = 2'd3; drain(3);
        check("mult3", TRIG, 0);
        MULT_REQ = 2'd2; PMT_MASK = 3'b001; drain(3);
        check("mult2_mask", TRIG, 0);
        PMT_MASK = 3'b000; drain(3);
        check("mult2_unmask", TRIG, 1);
        PMT_MASK = 3'b111; drain(3);
        check("mask_all", TRIG, 0);
        PMT_MASK = 3'b000; MULT_REQ = 2'd0;
        drain(130);
        phase_done("multiplicity");

        // Boundaries: equality not counted, saturation, MULT_REQ = 0, OCC_REQ = 0.
        THRES0 = 12'd500;
        repeat (10) run_tick(12'd500, 12'd0, 12'd0, 1'b0);
        drain(3);
        check("equal_not_counted", OCC0, 0);
        OCC_REQ = 7'd0; MULT_REQ = 2'd0; PMT_MASK = 3'b000;
        peak = 0; trig_any = 1'b0;
        repeat (300) begin
            run_tick(12'd4095, 12'd0, 12'd0, 1'b0);
            if (int'(OCC0) > peak) peak = int'(OCC0);
            if (TRIG) trig_any = 1'b1;
        end
        check("sat_occ0", OCC0, WINDOW);
        check("sat_peak", peak, WINDOW);
        check("mult0_no_trig", trig_any, 0);
        MULT_REQ = 2'd3; drain(2);
        check("occreq0_all_qualify", TRIG, 1);
        MULT_REQ = 2'd0;
        drain(125);
        phase_done("boundaries");

        // Non-tick cycles carry junk; nothing may move.
        THRES0 = 100; THRES1 = 100; THRES2 = 100;
        OCC_REQ = 7'd0; MULT_REQ = 2'd1; PMT_MASK = 3'b110;
        repeat (30) run_tick(12'd0, 12'd0, 12'd0, 1'b1);
        MULT_REQ = 2'd0;
        repeat (30) run_tick(12'd0, 12'd0, 12'd0, 1'b1);
        check("phasing_occ0", OCC0, 0);
        phase_done("enable40 phasing");

        // Sustained qualifying signal.
        OCC_REQ = 7'd10; MULT_REQ = 2'd1; PMT_MASK = 3'b110;
        trig_ticks = 0; rises = 0; prev_trig = 1'b0;
        repeat (400) begin
            run_tick(12'd4095, 12'd0, 12'd0, 1'b0);
            if (TRIG) trig_ticks++;
            if (TRIG && !prev_trig) rises++;
            prev_trig = TRIG;
        end
`ifdef COMPATIBILITY_TOTD_HOLDOFF_EN
        check("holdoff_pulses", rises, 4);
        check("holdoff_high_ticks", trig_ticks, 4);
`else
        check("level_rises", rises, 1);
        check("level_high_ticks", trig_ticks, 389);
`endif
        MULT_REQ = 2'd0;
        drain(125);
        phase_done("sustained");

        // Randomized traffic with a mid-stream reset.
        for (int t = 0; t < 1500; t++) begin
            logic [11:0] a [3];
            if (t % 100 == 0 || $urandom_range(0, 49) == 0) begin
                OCC_REQ  = 7'($urandom_range(0, 90));
                MULT_REQ = 2'($urandom_range(0, 3));
                PMT_MASK = 3'($urandom_range(0, 7));
                THRES0 = 12'($urandom_range(1000, 3000));
                THRES1 = 12'($urandom_range(1000, 3000));
                THRES2 = 12'($urandom_range(1000, 3000));
            end
            for (int i = 0; i < 3; i++) a[i] = 12'($urandom);
            if ($urandom_range(0, 7) == 0) a[0] = THRES0;
            if ($urandom_range(0, 7) == 0) a[1] = THRES1;
            if ($urandom_range(0, 7) == 0) a[2] = THRES2;
            run_tick(a[0], a[1], a[2], $urandom_range(0, 1) == 1);
            if (t == 700) midstream_reset();
        end
        phase_done("random");

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/totd_window_trigger.md
# totd_window_trigger

Time-over-Threshold-deconvolved (ToTd) window trigger. Consumes the three 40 MHz deconvolved FADC streams produced by the per-PMT deconvolution stages. Counts, per PMT, how many of the last 120 samples (3 µs) exceed a threshold, then raises TRIG when enough PMTs reach the required occupancy. Output feeds the SDE trigger OR / compatibility trigger logic; master enable and inhibits are applied externally.

## Interface
Parameters
- WINDOW, 120, window length in 40 MHz samples (1..127)
- OCC_WIDTH, 7, occupancy counter width; must hold WINDOW

Ports
- CLK  in  1  120 MHz clock
- RSTN  in  1  asynchronous active-low reset
- ENABLE40  in  2  40 MHz phase; logic advances only on CLK edges where ENABLE40 == 0 ("tick")
- ADC_IN0, ADC_IN1, ADC_IN2  in  12 each  deconvolved samples, one per PMT
- THRES0, THRES1, THRES2  in  12 each  per-PMT threshold, absolute ADC counts
- OCC_REQ  in  7  minimum per-PMT occupancy in window
- MULT_REQ  in  2  number of qualifying PMTs required (0 disables)
- PMT_MASK  in  3  bit i = 1 excludes PMT i from multiplicity
- OCC0, OCC1, OCC2  out  7 each  current window occupancy per PMT
- TRIG  out  1  ToTd trigger

## Operation
- Stage 1 (tick): OVER_i <= (ADC_IN_i > THRES_i), strict compare, unsigned.
- Stage 2 (tick): per PMT, shift OVER_i into a WINDOW-deep 1-bit delay line; OCC_i <= OCC_i + OVER_i − (bit leaving line). In and out both 1, or both 0 → unchanged. OCC_i is always in 0..WINDOW; never wraps.
- Stage 3 (tick): QUAL_i = !PMT_MASK[i] && (OCC_i >= OCC_REQ); NQ = QUAL_0+QUAL_1+QUAL_2; TRIG <= (MULT_REQ != 0) && (NQ >= MULT_REQ).
- OCC_REQ = 0 → every unmasked PMT qualifies. PMT_MASK = 3'b111 → TRIG never asserts.
- Config inputs (THRES, OCC_REQ, MULT_REQ, PMT_MASK) are sampled every tick; a change affects the next tick's evaluation. No settle period.
- Non-tick cycles: all registers hold.

## Timing
- Reset: OVER, delay lines, OCC0..2 = 0; TRIG = 0. Reset mid-window discards all history. After release, a full window must refill before old samples age out.
- Latency: sample on ADC_IN at tick n → OCC updated at tick n+2 → TRIG at tick n+3.
- A sample leaves the window WINDOW ticks after entering it, i.e. OCC_i decrements at tick n+2+WINDOW.
- TRIG and OCC change only on tick edges. They are stable for the full 3-cycle 40 MHz period.

## Configuration
- COMPATIBILITY_TOTD_HOLDOFF_EN defined:
  - TRIG is a single-tick pulse on the rising edge of the stage-3 condition.
  - After a pulse, TRIG is forced to 0 for the next WINDOW ticks, even if the condition re-rises.
  - Holdoff counter resets to 0 (not holding off).
  - Occupancy tracking continues during holdoff.
- Not defined: TRIG is a level equal to the stage-3 condition every tick. No holdoff logic is synthesized.

## Test plan
- Reset behaviour: RSTN low mid-stream → OCC0..2 = 0 and TRIG = 0 immediately. After release with ADC_IN = 0 → values stay 0.
- Window fill: THRES0 = 100, ADC_IN0 = 200 for 13 ticks then 0; OCC_REQ = 13, MULT_REQ = 1, mask 3'b110.
  - OCC0 ramps to 13.
  - TRIG = 1 at tick 3+12 = 15 after the first sample.
  - OCC0 falls to 12 at tick 2+120 and TRIG drops one tick later.
- Multiplicity: PMTs 0 and 1 at 20 bins, PMT2 at 0; MULT_REQ = 2 → TRIG = 1. MULT_REQ = 3 → TRIG = 0. Set PMT_MASK = 3'b001 with MULT_REQ = 2 → TRIG = 0.
- Boundaries:
  - ADC_IN = THRES → not counted.
  - Continuous over-threshold for 300 ticks → OCC saturates at exactly 120 with no wrap.
  - MULT_REQ = 0 → TRIG = 0 always.
- ENABLE40 phasing: vary ADC_IN on non-tick cycles only → no change in OCC or TRIG.
- Holdoff (macro on): sustained qualifying signal for 400 ticks → TRIG pulses at ticks t, t+121, t+242, … each one tick wide. With the macro off → TRIG stays high continuously.
